// File: rtl/byteblast_pkg.sv
// Shared ByteBlast definitions: lane count, select width, lane indices and
// the per-lane holding-register state.
package byteblast_pkg;

  localparam int unsigned LANES  = 4;
  localparam int unsigned SEL_W  = 2;
  localparam int unsigned XFER_W = 8;

  typedef logic [SEL_W-1:0] lane_sel_t;

  localparam lane_sel_t LANE_A = 2'd0;
  localparam lane_sel_t LANE_B = 2'd1;
  localparam lane_sel_t LANE_C = 2'd2;
  localparam lane_sel_t LANE_D = 2'd3;

  typedef enum logic {StEmpty, StFull} lane_state_e;

  function automatic logic [LANES-1:0] lane_decode(input lane_sel_t sel);
    return LANES'(1) << sel;
  endfunction

endpackage

// File: rtl/demux_lane.sv
// Single-entry holding register for one demux lane. A load takes priority
// over a drain, so load+drain passes the new word through without a bubble.
module demux_lane
  import byteblast_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            drain,
  input  logic [BITS-1:0] d,
  output logic            full,
  output logic [BITS-1:0] q
);

  lane_state_e     state_q;
  logic [BITS-1:0] data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
    end else if (load) begin
      state_q <= StFull;
      data_q  <= d;
    end else if (drain) begin
      // Data is left in place on drain; only the full flag clears.
      state_q <= StEmpty;
    end
  end

  assign full = (state_q == StFull);
  assign q    = data_q;

endmodule

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer with valid/ready handshaking and a
// free-running count of accepted input transfers.
module demux4_buf
  import byteblast_pkg::*;
#(
  parameter int unsigned BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  lane_sel_t         in_sel,
  input  logic [BITS-1:0]   in_data,
  output logic [LANES-1:0]  out_valid,
  input  logic [LANES-1:0]  out_ready,
  output logic [BITS-1:0]   out_a,
  output logic [BITS-1:0]   out_b,
  output logic [BITS-1:0]   out_c,
  output logic [BITS-1:0]   out_d,
  output logic [XFER_W-1:0] xfer_count
);

  logic [LANES-1:0]  lane_full;
  logic [LANES-1:0]  lane_load;
  logic [LANES-1:0]  lane_drain;
  logic [BITS-1:0]   lane_q [LANES];
  logic              accept;
  logic [XFER_W-1:0] xfer_count_q, xfer_count_d;

  // Depends only on in_sel and out_ready so upstream never sees a valid->ready loop.
  assign in_ready   = !lane_full[in_sel] || out_ready[in_sel];
  assign accept     = in_valid && in_ready;
  assign lane_load  = lane_decode(in_sel) & {LANES{accept}};
  assign lane_drain = lane_full & out_ready;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    demux_lane #(
      .BITS(BITS)
    ) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (lane_load[g]),
      .drain(lane_drain[g]),
      .d    (in_data),
      .full (lane_full[g]),
      .q    (lane_q[g])
    );
  end

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (accept) begin
      xfer_count_d = xfer_count_q + XFER_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count_q <= '0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign out_valid  = lane_full;
  assign out_a      = lane_q[LANE_A];
  assign out_b      = lane_q[LANE_B];
  assign out_c      = lane_q[LANE_C];
  assign out_d      = lane_q[LANE_D];
  assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_demux4_buf.sv
// Randomised and directed bench for demux4_buf against an array-based lane model.
module tb_demux4_buf;

  localparam int unsigned BITS = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [1:0]      in_sel = 2'd0;
  logic [BITS-1:0] in_data = '0;
  logic [3:0]      out_valid;
  logic [3:0]      out_ready = 4'd0;
  logic [BITS-1:0] out_a, out_b, out_c, out_d;
  logic [7:0]      xfer_count;

  demux4_buf #(
    .BITS(BITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sel    (in_sel),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_c     (out_c),
    .out_d     (out_d),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Behavioural model: one flag and one word per lane plus a transfer count.
  bit              m_full [4];
  logic [BITS-1:0] m_data [4];
  int              m_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin : model
    bit              nf [4];
    logic [BITS-1:0] nd [4];
    int              nc;
    bit              acc;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_full[i] <= 1'b0;
        m_data[i] <= '0;
      end
      m_cnt <= 0;
    end else begin
      nf = m_full;
      nd = m_data;
      nc = m_cnt;
      acc = in_valid && (!m_full[in_sel] || out_ready[in_sel]);
      for (int i = 0; i < 4; i++) if (m_full[i] && out_ready[i]) nf[i] = 1'b0;
      if (acc) begin
        nf[in_sel] = 1'b1;
        nd[in_sel] = in_data;
        nc = (nc + 1) % 256;
      end
      m_full <= nf;
      m_data <= nd;
      m_cnt  <= nc;
    end
  end

  always @(negedge clk) begin : compare
    logic [3:0] ev;
    if (chk_en && rst_n) begin
      for (int i = 0; i < 4; i++) ev[i] = m_full[i];
      check("out_valid", 32'(out_valid), 32'(ev));
      check("out_a", 32'(out_a), 32'(m_data[0]));
      check("out_b", 32'(out_b), 32'(m_data[1]));
      check("out_c", 32'(out_c), 32'(m_data[2]));
      check("out_d", 32'(out_d), 32'(m_data[3]));
      check("xfer_count", 32'(xfer_count), 32'(m_cnt));
      check("in_ready", 32'(in_ready), 32'(!m_full[in_sel] || out_ready[in_sel]));
    end
  end

  task automatic drive(input bit v, input logic [1:0] s, input logic [7:0] d,
                       input logic [3:0] r);
    in_valid  = v;
    in_sel    = s;
    in_data   = d;
    out_ready = r;
  endtask

  // Advance one clock; returns just after the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    drive(0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    #1;
    check("rst out_valid", 32'(out_valid), 32'h0);
    check("rst out_a", 32'(out_a), 32'h0);
    check("rst out_d", 32'(out_d), 32'h0);
    check("rst xfer_count", 32'(xfer_count), 32'h0);
    check("rst in_ready", 32'(in_ready), 32'h1);

    drive(1, 0, 8'h11, 0); tick();
    drive(1, 1, 8'h22, 0); tick();
    drive(1, 2, 8'h33, 0); tick();
    drive(1, 3, 8'h44, 0); tick();
    check("fill out_valid", 32'(out_valid), 32'hf);
    check("fill out_a", 32'(out_a), 32'h11);
    check("fill out_b", 32'(out_b), 32'h22);
    check("fill out_c", 32'(out_c), 32'h33);
    check("fill out_d", 32'(out_d), 32'h44);
    check("fill count", 32'(xfer_count), 32'd4);
    drive(1, 2, 8'h55, 0);
    #1 check("stall in_ready", 32'(in_ready), 32'h0);
    tick();
    check("stall out_c", 32'(out_c), 32'h33);
    check("stall count", 32'(xfer_count), 32'd4);

    drive(1, 2, 8'h77, 4'b0100);
    #1 check("pass in_ready", 32'(in_ready), 32'h1);
    tick();
    check("pass out_c", 32'(out_c), 32'h77);
    check("pass valid_c", 32'(out_valid[2]), 32'h1);
    check("pass count", 32'(xfer_count), 32'd5);

    for (int k = 0; k < 4; k++) begin
      drive(1, 1, 8'hA0 + 8'(k), 4'b0010);
      tick();
      check("stream out_b", 32'(out_b), 32'hA0 + 32'(k));
      check("stream out_a", 32'(out_a), 32'h11);
    end
    check("stream count", 32'(xfer_count), 32'd9);

    for (int k = 0; k < 400; k++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 4'($urandom));
      tick();
    end

    pulse_reset();
    for (int k = 0; k < 256; k++) begin
      drive(1, 2'(k), 8'(k), 4'hf);
      tick();
    end
    check("wrap count", 32'(xfer_count), 32'd0);

    pulse_reset();
    drive(1, 1, 8'hBB, 0); tick();
    drive(1, 3, 8'hDD, 0); tick();
    drive(0, 0, 0, 0);
    check("pre-rst out_valid", 32'(out_valid), 32'b1010);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async out_valid", 32'(out_valid), 32'h0);
    check("async out_d", 32'(out_d), 32'h0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    drive(1, 3, 8'h5A, 0); tick();
    check("post-rst out_valid", 32'(out_valid), 32'b1000);
    check("post-rst out_d", 32'(out_d), 32'h5A);
    check("post-rst count", 32'(xfer_count), 32'd1);

    drive(0, 0, 0, 4'hf);
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
